seg7_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver. It scans `DIGITS` common-anode digit positions, decoding one hex nibble per position, with per-digit blanking, decimal points, PWM brightness and a tear-free frame snapshot. It sits between the design's data path and the board's segment and digit-select pins, and replaces the fixed 4-digit, 2-nibble driver.

---
 rtl/seg7_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment driver for DIGITS positions.
// Scans from the leftmost digit down to digit 0, decodes one hex nibble per slot,
// applies per-digit blanking, decimal points and 16-level PWM brightness.
// All displayed values come from shadow registers refreshed once per frame,
// so the data path may change its inputs at any time without tearing.
// Optional feature macro: SEG7_LZB_EN enables leading-zero blanking via `lzb`.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [3:0]            bright,
    input  logic                  lzb,
    output logic [DIGITS-1:0]     indikators,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int PTR_W = $clog2(DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div;
    logic [PTR_W-1:0]    ptr;
    logic [3:0]          pwm;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   shadow_blank;
    logic [3:0]          shadow_bright;
    logic [DIGITS-1:0]   snap_blank;

    logic [3:0]          cur_nibble;
    logic                lit;

    // Hex digit to segment pattern, a = bit 6 ... g = bit 0.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick = (div == DIV_LAST);
    assign wrap = tick && (ptr == '0);

`ifdef SEG7_LZB_EN
    // Blank mask to store at snapshot time: user mask plus leading zeros when requested.
    always_comb begin
        logic leading;
        snap_blank = blank;
        leading    = lzb;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading && (data[4*k +: 4] == 4'h0)) begin
                snap_blank[k] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    logic unused_lzb;
    assign unused_lzb = lzb;

    // Without leading-zero blanking the stored mask is just the user mask.
    always_comb begin
        snap_blank = blank;
    end
`endif

    // Slot divider: counts SCAN_DIV cycles per digit slot.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Digit pointer: walks from the leftmost digit down to 0 on each tick.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ptr <= PTR_FIRST;
        end else if (tick) begin
            if (ptr == '0) begin
                ptr <= PTR_FIRST;
            end else begin
                ptr <= ptr - 1'b1;
            end
        end
    end

    // Free-running PWM phase counter.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 1'b1;
        end
    end

    // Frame snapshot of all display inputs, flagged by a one-cycle frame_start.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shadow_data   <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            shadow_bright <= '0;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                shadow_data   <= data;
                shadow_dp     <= dp_in;
                shadow_blank  <= snap_blank;
                shadow_bright <= bright;
            end
        end
    end

    assign cur_nibble = shadow_data[4*ptr +: 4];
    assign lit        = !shadow_blank[ptr] && (pwm <= shadow_bright);

    // Registered pin drivers; a dark digit releases all selects and segments.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            indikators <= '1;
            segments   <= '0;
            dp         <= 1'b0;
        end else if (lit) begin
            indikators <= ~(DIGITS'(1) << ptr);
            segments   <= decode(cur_nibble);
            dp         <= shadow_dp[ptr];
        end else begin
            indikators <= '1;
            segments   <= '0;
            dp         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=16).
// The reference model predicts every output from the cycle count since reset
// and a frame-level copy of the inputs, using plain arithmetic.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int S  = 16;
    localparam int DS = D * S;
`ifdef SEG7_LZB_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic        sclk = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  bright;
    logic        lzb;
    logic [3:0]  indikators;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic [3:0]  sh_bright;
    logic [3:0]  exp_ind;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;

    logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .sclk(sclk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank),
        .bright(bright), .lzb(lzb), .indikators(indikators), .segments(segments),
        .dp(dp), .frame_start(frame_start)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout n=%0d got running want finished", n);
        $fatal(1, "[TB] simulation time limit");
    end

    // Digits above the highest nonzero nibble are dark when leading-zero blanking applies.
    function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic [3:0] b, input logic z);
        logic [3:0] r;
        int hi;
        r = b;
        if (LZB_ON && z) begin
            hi = 0;
            for (int k = 1; k < D; k++) if ((d >> (4 * k)) != 16'h0) hi = k;
            for (int k = hi + 1; k < D; k++) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Advance one clock and predict the outputs that follow that edge.
    task automatic step();
        int m, p, ph;
        bit on;
        @(posedge sclk);
        n++;
        m  = n - 1;
        p  = D - 1 - ((m / S) % D);
        ph = m % 16;
        on = !sh_blank[p] && (ph <= int'(sh_bright));
        exp_ind = on ? ~(4'b0001 << p) : 4'hF;
        exp_seg = on ? dec_tab[sh_data[4*p +: 4]] : 7'h00;
        exp_dp  = on ? sh_dp[p] : 1'b0;
        exp_fs  = (n % DS == 0);
        if (exp_fs) begin
            sh_data   = data;
            sh_dp     = dp_in;
            sh_blank  = lz_mask(data, blank, lzb);
            sh_bright = bright;
        end
        #1;
    endtask

    task automatic model_reset();
        n = 0;
        sh_data = '0; sh_dp = '0; sh_blank = '0; sh_bright = '0;
    endtask

    task automatic test_reset();
        data = 16'h1234; dp_in = 4'h0; blank = 4'h0; bright = 4'hF; lzb = 1'b0;
        rst = 1'b1;
        #23;
        checks++;
        if ({indikators, segments, dp, frame_start} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got %h want %h", {indikators, segments, dp, frame_start}, {4'hF, 7'h00, 1'b0, 1'b0});
        end
        @(negedge sclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < DS; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL first_frame n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
            if (indikators !== 4'hF) begin
                checks++;
                if (segments !== 7'h7E) begin
                    errors++;
                    $display("[TB] FAIL pre_snapshot_seg n=%0d got %h want 7e", n, segments);
                end
            end
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_frame_start n=%0d got %b want 1", n, frame_start);
        end
        step();
        checks++;
        if ({indikators, segments} !== {4'b0111, 7'h30}) begin
            errors++;
            $display("[TB] FAIL first_digit3 got %h want %h", {indikators, segments}, {4'b0111, 7'h30});
        end
    endtask

    task automatic test_mid_frame_change();
        bool_loop: for (int i = 0; i < DS && (n % DS) != DS / 2; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL mid_frame_pre n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
        end
        data = 16'hABCD;
        for (int i = 0; i <= DS; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL mid_frame n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
            if (frame_start === 1'b1) break;
            if (i == DS) begin
                errors++;
                $display("[TB] FAIL mid_frame_wait got no frame_start want frame_start");
            end
        end
        step();
        checks++;
        if ({indikators, segments} !== {4'b0111, 7'h77}) begin
            errors++;
            $display("[TB] FAIL new_frame_digit3 got %h want %h", {indikators, segments}, {4'b0111, 7'h77});
        end
    endtask

    task automatic test_blank_dp_bright();
        int lit_cnt, dp_cnt, d2_cnt;
        data = 16'h1234; blank = 4'b0100; dp_in = 4'b0001; bright = 4'd3;
        for (int i = 0; i <= DS; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL bdb_wait n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
            if (frame_start === 1'b1) break;
            if (i == DS) begin
                errors++;
                $display("[TB] FAIL bdb_wait got no frame_start want frame_start");
            end
        end
        lit_cnt = 0; dp_cnt = 0; d2_cnt = 0;
        for (int i = 0; i < DS; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL blank_dp_bright n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
            if (indikators !== 4'hF) lit_cnt++;
            if (dp === 1'b1) dp_cnt++;
            if (indikators === 4'b1011) d2_cnt++;
        end
        checks++;
        if (lit_cnt != 12) begin
            errors++;
            $display("[TB] FAIL pwm_lit_cycles got %0d want 12", lit_cnt);
        end
        checks++;
        if (dp_cnt != 4) begin
            errors++;
            $display("[TB] FAIL dp_cycles got %0d want 4", dp_cnt);
        end
        checks++;
        if (d2_cnt != 0) begin
            errors++;
            $display("[TB] FAIL blanked_digit2 got %0d want 0", d2_cnt);
        end
    endtask

    task automatic test_lzb();
        int cnt [4];
        int seg_bad;
        logic [15:0] vals [2];
        logic [6:0]  d0_seg [2];
        vals[0] = 16'h0005; vals[1] = 16'h0000;
        d0_seg[0] = 7'h5B;  d0_seg[1] = 7'h7E;
        blank = 4'h0; dp_in = 4'h0; bright = 4'hF; lzb = 1'b1;
        for (int v = 0; v < 2; v++) begin
            data = vals[v];
            for (int i = 0; i <= DS; i++) begin
                step();
                checks++;
                if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                    errors++;
                    $display("[TB] FAIL lzb_wait n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
                end
                if (frame_start === 1'b1) break;
                if (i == DS) begin
                    errors++;
                    $display("[TB] FAIL lzb_wait got no frame_start want frame_start");
                end
            end
            for (int k = 0; k < D; k++) cnt[k] = 0;
            seg_bad = 0;
            for (int i = 0; i < DS; i++) begin
                step();
                checks++;
                if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                    errors++;
                    $display("[TB] FAIL lzb n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
                end
                for (int k = 0; k < D; k++) if (indikators === ~(4'b0001 << k)) cnt[k]++;
                if (indikators === 4'b1110 && segments !== d0_seg[v]) seg_bad++;
            end
            for (int k = 0; k < D; k++) begin
                checks++;
                if (cnt[k] != ((LZB_ON && k > 0) ? 0 : S)) begin
                    errors++;
                    $display("[TB] FAIL lzb_digit%0d_cycles got %0d want %0d", k, cnt[k], (LZB_ON && k > 0) ? 0 : S);
                end
            end
            checks++;
            if (seg_bad != 0) begin
                errors++;
                $display("[TB] FAIL lzb_digit0_seg got %0d bad cycles want 0", seg_bad);
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * DS; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                data   = 16'($urandom);
                dp_in  = 4'($urandom_range(0, 15));
                blank  = 4'($urandom_range(0, 15));
                bright = 4'($urandom_range(0, 15));
                lzb    = 1'($urandom_range(0, 1));
            end
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL random n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < S && (n % S) != 7; i++) step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({indikators, segments, dp, frame_start} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset got %h want %h", {indikators, segments, dp, frame_start}, {4'hF, 7'h00, 1'b0, 1'b0});
        end
        #2;
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if ({indikators, segments, dp} !== {4'b0111, 7'h7E, 1'b0}) begin
            errors++;
            $display("[TB] FAIL restart_digit3 got %h want %h", {indikators, segments, dp}, {4'b0111, 7'h7E, 1'b0});
        end
        for (int i = 0; i < DS + S; i++) begin
            step();
            checks++;
            if ({indikators, segments, dp, frame_start} !== {exp_ind, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("[TB] FAIL after_reset n=%0d got %h want %h", n, {indikators, segments, dp, frame_start}, {exp_ind, exp_seg, exp_dp, exp_fs});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_mid_frame_change();
        test_blank_dp_bright();
        test_lzb();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
